// File: rtl/mvm_dot_feeder.sv
// Producer side of the 8-lane dot pipeline: walks an R x C matrix-vector job and streams chunk operands.
// Optional macro FEEDER_HOLD_EN adds i_hold, which stalls issue while in ISSUE.
module mvm_dot_feeder #(
  parameter int IWIDTH = 8,
  parameter int RW     = 8,
  parameter int CW     = 8,
  parameter int MADDRW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [RW-1:0]       i_cfg_rows,
  input  logic [CW-1:0]       i_cfg_chunks,
`ifdef FEEDER_HOLD_EN
  input  logic                i_hold,
`endif
  output logic                o_vmem_ren,
  output logic [CW-1:0]       o_vmem_raddr,
  input  logic [8*IWIDTH-1:0] i_vmem_rdata,
  output logic                o_mmem_ren,
  output logic [MADDRW-1:0]   o_mmem_raddr,
  input  logic [8*IWIDTH-1:0] i_mmem_rdata,
  output logic [8*IWIDTH-1:0] o_dot_vec0,
  output logic [8*IWIDTH-1:0] o_dot_vec1,
  output logic                o_dot_ivalid,
  output logic                o_dot_first,
  output logic                o_dot_last,
  output logic [RW-1:0]       o_dot_row,
  output logic                o_busy,
  output logic                o_done
);

  localparam int DW = 8 * IWIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [RW-1:0]     r_rows;
  logic [CW-1:0]     r_chunks;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_chunk;
  logic [MADDRW-1:0] r_maddr;
  logic              r_ren;
  logic              r_busy;

  logic              r_s1_valid;
  logic              r_s1_first;
  logic              r_s1_last;
  logic              r_s1_end;
  logic [RW-1:0]     r_s1_row;

  logic              r_ivalid;
  logic              r_first;
  logic              r_last;
  logic [RW-1:0]     r_row_out;
  logic [DW-1:0]     r_vec0;
  logic [DW-1:0]     r_vec1;
  logic              r_done;

  logic              w_hold;
  logic              w_zero_job;
  logic              w_last_chunk;
  logic              w_last_row;
  logic              w_job_end;

`ifdef FEEDER_HOLD_EN
  assign w_hold = i_hold;
`else
  assign w_hold = 1'b0;
`endif

  assign w_zero_job   = (i_cfg_rows == '0) || (i_cfg_chunks == '0);
  assign w_last_chunk = (r_chunk == r_chunks - CW'(1));
  assign w_last_row   = (r_row == r_rows - RW'(1));
  assign w_job_end    = w_last_chunk && w_last_row;

  // r_ren marks the cycle in which the current counters are being read;
  // counters advance after every real issue, hold only gates the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rows   <= '0;
      r_chunks <= '0;
      r_row    <= '0;
      r_chunk  <= '0;
      r_maddr  <= '0;
      r_ren    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ren  <= 1'b0;
          r_busy <= 1'b0;
          if (i_start && !w_zero_job) begin
            r_state  <= S_ISSUE;
            r_rows   <= i_cfg_rows;
            r_chunks <= i_cfg_chunks;
            r_row    <= '0;
            r_chunk  <= '0;
            r_maddr  <= '0;
            r_ren    <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_busy <= 1'b1;
          if (r_ren) begin
            r_maddr <= r_maddr + MADDRW'(1);
            if (w_last_chunk) begin
              r_chunk <= '0;
              r_row   <= r_row + RW'(1);
            end else begin
              r_chunk <= r_chunk + CW'(1);
            end
            if (w_job_end) begin
              r_state <= S_DRAIN;
              r_ren   <= 1'b0;
            end else begin
              r_ren <= !w_hold;
            end
          end else begin
            r_ren <= !w_hold;
          end
        end
        S_DRAIN: begin
          r_ren <= 1'b0;
          if (r_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_busy <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ren   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Tag stage lines up with the RAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_end   <= 1'b0;
      r_s1_row   <= '0;
    end else begin
      r_s1_valid <= r_ren;
      r_s1_first <= r_ren && (r_chunk == '0);
      r_s1_last  <= r_ren && w_last_chunk;
      r_s1_end   <= r_ren && w_job_end;
      r_s1_row   <= r_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ivalid  <= 1'b0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_row_out <= '0;
      r_vec0    <= '0;
      r_vec1    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_ivalid <= r_s1_valid;
      r_first  <= r_s1_valid && r_s1_first;
      r_last   <= r_s1_valid && r_s1_last;
      r_done   <= (r_s1_valid && r_s1_end) ||
                  ((r_state == S_IDLE) && i_start && w_zero_job);
      if (r_s1_valid) begin
        r_vec0    <= i_mmem_rdata;
        r_vec1    <= i_vmem_rdata;
        r_row_out <= r_s1_row;
      end
    end
  end

  assign o_vmem_ren   = r_ren;
  assign o_mmem_ren   = r_ren;
  assign o_vmem_raddr = r_chunk;
  assign o_mmem_raddr = r_maddr;
  assign o_dot_vec0   = r_vec0;
  assign o_dot_vec1   = r_vec1;
  assign o_dot_ivalid = r_ivalid;
  assign o_dot_first  = r_first;
  assign o_dot_last   = r_last;
  assign o_dot_row    = r_row_out;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_mvm_dot_feeder.sv
// Self-checking bench for mvm_dot_feeder; hold scenario runs only when FEEDER_HOLD_EN is defined.
module tb_mvm_dot_feeder;
  localparam int IWIDTH = 8;
  localparam int RW     = 8;
  localparam int CW     = 8;
  localparam int MADDRW = 16;
  localparam int DW     = 8 * IWIDTH;

  logic              clk;
  logic              rst;
  logic              start;
  logic [RW-1:0]     cfg_rows;
  logic [CW-1:0]     cfg_chunks;
  logic              hold;
  logic              vmem_ren;
  logic [CW-1:0]     vmem_raddr;
  logic [DW-1:0]     vmem_rdata;
  logic              mmem_ren;
  logic [MADDRW-1:0] mmem_raddr;
  logic [DW-1:0]     mmem_rdata;
  logic [DW-1:0]     dot_vec0;
  logic [DW-1:0]     dot_vec1;
  logic              dot_ivalid;
  logic              dot_first;
  logic              dot_last;
  logic [RW-1:0]     dot_row;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  bit fixed_data = 0;
  logic [31:0] seed_m;
  logic [31:0] seed_v;

  mvm_dot_feeder #(.IWIDTH(IWIDTH), .RW(RW), .CW(CW), .MADDRW(MADDRW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_cfg_rows   (cfg_rows),
    .i_cfg_chunks (cfg_chunks),
`ifdef FEEDER_HOLD_EN
    .i_hold       (hold),
`endif
    .o_vmem_ren   (vmem_ren),
    .o_vmem_raddr (vmem_raddr),
    .i_vmem_rdata (vmem_rdata),
    .o_mmem_ren   (mmem_ren),
    .o_mmem_raddr (mmem_raddr),
    .i_mmem_rdata (mmem_rdata),
    .o_dot_vec0   (dot_vec0),
    .o_dot_vec1   (dot_vec1),
    .o_dot_ivalid (dot_ivalid),
    .o_dot_first  (dot_first),
    .o_dot_last   (dot_last),
    .o_dot_row    (dot_row),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of the two RAMs as a function of address.
  function automatic logic [DW-1:0] mword(input int a);
    if (fixed_data) return 64'h7F80_0102_FEFF_0010;
    return {(32'(a) * 32'h9E37_79B1) ^ seed_m, 32'(a) ^ 32'hA5A5_0000 ^ seed_m};
  endfunction

  function automatic logic [DW-1:0] vword(input int a);
    if (fixed_data) return 64'h0102_0304_0506_0708;
    return {32'(a) ^ seed_v, (32'(a) * 32'h0101_0101) + seed_v};
  endfunction

  always @(posedge clk) begin
    if (mmem_ren) mmem_rdata <= mword(int'(mmem_raddr));
    if (vmem_ren) vmem_rdata <= vword(int'(vmem_raddr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cfg_rows = '0; cfg_chunks = '0; hold = 1'b0;
    repeat (3) tick();
    checks++;
    if (vmem_ren !== 1'b0 || mmem_ren !== 1'b0 || vmem_raddr !== '0 || mmem_raddr !== '0) begin
      errors++; $display("FAIL reset_rd: ren=%b/%b addr=%0d/%0d required 0", vmem_ren, mmem_ren, vmem_raddr, mmem_raddr);
    end
    checks++;
    if (dot_vec0 !== '0 || dot_vec1 !== '0 || dot_ivalid !== 1'b0 || dot_first !== 1'b0 ||
        dot_last !== 1'b0 || dot_row !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_dot: iv=%b f=%b l=%b row=%0d busy=%b done=%b required all 0",
                         dot_ivalid, dot_first, dot_last, dot_row, busy, done);
    end
    rst = 1'b0;
    tick();
  endtask

  // Runs one job started at the next edge and checks every cycle against the
  // chunk sequence i = 0..R*C-1 (row i/C, chunk i%C, matrix address i).
  task automatic test_job(input int R, input int C, input bit noise);
    int n, i;
    logic exp_ren, exp_iv;
    n = R * C;
    cfg_rows = RW'(R); cfg_chunks = CW'(C); start = 1'b1;
    tick();
    for (int j = 1; j <= n + 3; j++) begin
      exp_ren = (j <= n);
      exp_iv  = (j >= 3) && (j <= n + 2);
      i = j - 3;
      checks++;
      if (vmem_ren !== exp_ren || mmem_ren !== exp_ren) begin
        errors++; $display("FAIL ren c%0d R%0d C%0d: %b/%b required %b", j, R, C, vmem_ren, mmem_ren, exp_ren);
      end
      if (exp_ren) begin
        checks++;
        if (vmem_raddr !== CW'((j - 1) % C) || mmem_raddr !== MADDRW'(j - 1)) begin
          errors++; $display("FAIL raddr c%0d: v=%0d m=%0d required v=%0d m=%0d",
                             j, vmem_raddr, mmem_raddr, (j - 1) % C, j - 1);
        end
      end
      checks++;
      if (dot_ivalid !== exp_iv) begin
        errors++; $display("FAIL ivalid c%0d R%0d C%0d: %b required %b", j, R, C, dot_ivalid, exp_iv);
      end
      if (exp_iv) begin
        checks++;
        if (dot_first !== (i % C == 0) || dot_last !== (i % C == C - 1) || dot_row !== RW'(i / C)) begin
          errors++; $display("FAIL tag chunk%0d: f=%b l=%b row=%0d required f=%b l=%b row=%0d",
                             i, dot_first, dot_last, dot_row, (i % C == 0), (i % C == C - 1), i / C);
        end
        checks++;
        if (dot_vec0 !== mword(i) || dot_vec1 !== vword(i % C)) begin
          errors++; $display("FAIL data chunk%0d: vec0=%h vec1=%h required %h %h",
                             i, dot_vec0, dot_vec1, mword(i), vword(i % C));
        end
      end else begin
        checks++;
        if (dot_first !== 1'b0 || dot_last !== 1'b0) begin
          errors++; $display("FAIL tag_idle c%0d: f=%b l=%b required 0", j, dot_first, dot_last);
        end
      end
      if (j == n + 3) begin
        checks++;
        if (dot_vec0 !== mword(n - 1) || dot_vec1 !== vword((n - 1) % C) || dot_row !== RW'((n - 1) / C)) begin
          errors++; $display("FAIL hold_vals: vec0=%h vec1=%h row=%0d required %h %h %0d",
                             dot_vec0, dot_vec1, dot_row, mword(n - 1), vword((n - 1) % C), (n - 1) / C);
        end
      end
      checks++;
      if (done !== (j == n + 2) || busy !== (j <= n + 2)) begin
        errors++; $display("FAIL done_busy c%0d: done=%b busy=%b required %b %b", j, done, busy, (j == n + 2), (j <= n + 2));
      end
      if (noise && j <= n + 2) begin
        start = 1'($urandom_range(0, 1));
        cfg_rows = RW'($urandom_range(0, 3));
        cfg_chunks = CW'($urandom_range(0, 3));
      end else begin
        start = 1'b0;
      end
      if (j < n + 3) tick();
    end
  endtask

  task automatic test_zero_size();
    for (int k = 0; k < 2; k++) begin
      cfg_rows = (k == 0) ? RW'(0) : RW'(3);
      cfg_chunks = (k == 0) ? CW'(4) : CW'(0);
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || vmem_ren !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL zero_done case%0d: done=%b ren=%b busy=%b required 1 0 0", k, done, vmem_ren, busy);
      end
      for (int j = 0; j < 3; j++) begin
        tick();
        checks++;
        if (done !== 1'b0 || vmem_ren !== 1'b0 || mmem_ren !== 1'b0 || busy !== 1'b0 || dot_ivalid !== 1'b0) begin
          errors++; $display("FAIL zero_after case%0d: done=%b ren=%b busy=%b iv=%b required 0",
                             k, done, vmem_ren, busy, dot_ivalid);
        end
      end
    end
  endtask

  task automatic test_reset_midjob();
    cfg_rows = RW'(2); cfg_chunks = CW'(2); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (dot_ivalid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL midjob_run: iv=%b busy=%b required 1 1", dot_ivalid, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (vmem_ren !== 1'b0 || mmem_ren !== 1'b0 || vmem_raddr !== '0 || mmem_raddr !== '0 ||
        dot_vec0 !== '0 || dot_vec1 !== '0 || dot_ivalid !== 1'b0 || dot_row !== '0 ||
        dot_first !== 1'b0 || dot_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midjob_rst: ren=%b iv=%b busy=%b done=%b required all 0", vmem_ren, dot_ivalid, busy, done);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++;
      if (vmem_ren !== 1'b0 || dot_ivalid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL midjob_after c%0d: ren=%b iv=%b done=%b busy=%b required 0", j, vmem_ren, dot_ivalid, done, busy);
      end
    end
    test_job(1, 1, 1'b0);
  endtask

  task automatic test_fixed_data();
    fixed_data = 1'b1;
    test_job(1, 2, 1'b0);
    fixed_data = 1'b0;
  endtask

  task automatic test_back_to_back();
    test_job(1, 4, 1'b1);
    test_job(2, 2, 1'b0);
  endtask

  task automatic test_random_jobs();
    for (int k = 0; k < 6; k++) begin
      seed_m = $urandom;
      seed_v = $urandom;
      test_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 5)), 1'b1);
    end
  endtask

`ifdef FEEDER_HOLD_EN
  // Hold sampled at the edges closing cycles 1 and 2 removes the issues of cycles 2 and 3.
  task automatic test_hold();
    int issue_cyc[4] = '{1, 4, 5, 6};
    int idx_r, idx_v;
    cfg_rows = RW'(1); cfg_chunks = CW'(4); start = 1'b1;
    tick();
    for (int j = 1; j <= 9; j++) begin
      idx_r = -1; idx_v = -1;
      for (int k = 0; k < 4; k++) begin
        if (issue_cyc[k] == j) idx_r = k;
        if (issue_cyc[k] + 2 == j) idx_v = k;
      end
      checks++;
      if (vmem_ren !== (idx_r >= 0) || (idx_r >= 0 && (vmem_raddr !== CW'(idx_r) || mmem_raddr !== MADDRW'(idx_r)))) begin
        errors++; $display("FAIL hold_ren c%0d: ren=%b v=%0d m=%0d required ren=%b addr=%0d",
                           j, vmem_ren, vmem_raddr, mmem_raddr, (idx_r >= 0), idx_r);
      end
      checks++;
      if (dot_ivalid !== (idx_v >= 0) || (idx_v >= 0 && dot_vec0 !== mword(idx_v))) begin
        errors++; $display("FAIL hold_iv c%0d: iv=%b vec0=%h required iv=%b chunk%0d", j, dot_ivalid, dot_vec0, (idx_v >= 0), idx_v);
      end
      checks++;
      if (done !== (j == 8) || busy !== (j <= 8)) begin
        errors++; $display("FAIL hold_done c%0d: done=%b busy=%b required %b %b", j, done, busy, (j == 8), (j <= 8));
      end
      start = 1'b0;
      hold = (j == 1 || j == 2);
      if (j < 9) tick();
    end
    hold = 1'b0;
  endtask
`endif

  initial begin
    seed_m = 32'h1357_9BDF;
    seed_v = 32'h2468_ACE0;
    mmem_rdata = '0;
    vmem_rdata = '0;
    test_reset();
    test_job(2, 3, 1'b0);
    test_fixed_data();
    test_zero_size();
    test_back_to_back();
    test_reset_midjob();
    test_job(3, 1, 1'b0);
    test_random_jobs();
`ifdef FEEDER_HOLD_EN
    test_hold();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mvm_dot_feeder.md
Name: mvm_dot_feeder

Overview:
- Producer side of the 8-lane dot-product pipeline (vec0/vec1/ivalid interface).
- On start, walks an R x C matrix-vector job: for each row, issues C 8-element chunks.
- For each chunk, reads one matrix word and one vector word from synchronous RAMs and presents them to the dot unit.
- Tags each issued chunk with first/last/row so the downstream accumulator can sum chunk results per row.
- Fully streaming: one chunk per cycle, no downstream back-pressure.

Parameters:
- IWIDTH, 8, signed element width; memory word and dot operand width = 8*IWIDTH.
- RW, 8, width of row count/index.
- CW, 8, width of chunk count; also vector memory address width.
- MADDRW, 16, matrix memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- cfg_rows  in  RW  number of rows R; sampled with start.
- cfg_chunks  in  CW  chunks per row C; sampled with start.
- vmem_ren  out  1  vector RAM read enable.
- vmem_raddr  out  CW  vector RAM address.
- vmem_rdata  in  8*IWIDTH  vector RAM data, valid the cycle after ren.
- mmem_ren  out  1  matrix RAM read enable.
- mmem_raddr  out  MADDRW  matrix RAM address.
- mmem_rdata  in  8*IWIDTH  matrix RAM data, valid the cycle after ren.
- dot_vec0  out  8*IWIDTH  matrix chunk, registered; lane 0 in the MSBs.
- dot_vec1  out  8*IWIDTH  vector chunk, registered; same lane order.
- dot_ivalid  out  1  operands valid.
- dot_first  out  1  chunk 0 of a row; qualified by dot_ivalid.
- dot_last  out  1  chunk C-1 of a row; qualified by dot_ivalid.
- dot_row  out  RW  row index of the presented chunk.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.

Behaviour:
- Reset: every output is 0, state is IDLE, counters are 0.
- Reset mid-job aborts the job immediately; no done pulse is produced.
- All outputs are registered.
- States:
  - IDLE: busy=0.
    - start=1 with R!=0 and C!=0: latch R and C, clear row/chunk/maddr counters, go to ISSUE.
    - start=1 with R==0 or C==0: done=1 for the next cycle only; stay IDLE; no reads issued.
  - ISSUE: busy=1.
    - Each cycle: vmem_ren=mmem_ren=1, vmem_raddr=chunk, mmem_raddr=maddr.
    - After each issue: chunk++; maddr++ (running counter, no multiplier; wraps mod 2^MADDRW).
    - When chunk==C-1: chunk wraps to 0 and row++.
    - After issuing (row=R-1, chunk=C-1): go to DRAIN with ren=0.
  - DRAIN: busy=1; ren=0; wait for the last issued chunk to emerge.
    - Go to IDLE the cycle after the final dot_ivalid.
- Pipeline:
  - Read issued in cycle k; RAM data valid in cycle k+1; dot_* registered and valid in cycle k+2.
  - The first/last/row tag travels in a 2-stage shift register alongside ren.
  - dot_ivalid is ren delayed by 2 cycles.
- Timing with start sampled at edge T and N = R*C chunks:
  - ren high cycles T+1..T+N.
  - dot_ivalid high cycles T+3..T+N+2.
  - done=1 and busy=1 in cycle T+N+2, coincident with the final dot_ivalid and dot_last.
  - busy=0 from T+N+3.
- When dot_ivalid=0: dot_vec0/dot_vec1/dot_row hold their last values; dot_first/dot_last are 0.
- start while busy is ignored.
- start in the cycle after done is accepted normally.
- Special cases:
  - C==1: every chunk has first=last=1.
  - R==1: row tag is 0 for all chunks.
- Operand data is passed through unmodified; no arithmetic on data.

Optional Feature:
- Macro FEEDER_HOLD_EN.
- Defined: adds input port hold (1 bit). In ISSUE, hold=1 suppresses ren for that cycle and freezes the counters.
  - Reads already in flight still emerge 2 cycles after issue, so dot_ivalid gaps mirror hold gaps.
  - done still coincides with the final dot_ivalid.
  - hold is ignored in IDLE and DRAIN.
- Not defined: no hold port; issue is unconditional, one chunk per cycle.

Test Plan:
- R=2, C=3, start at edge 0:
  - ren in cycles 1-6; mmem_raddr 0..5; vmem_raddr 0,1,2,0,1,2.
  - dot_ivalid in cycles 3-8; first at cycles 3 and 6; last at cycles 5 and 8; dot_row 0,0,0,1,1,1.
  - done in cycle 8 only; busy in cycles 1-8.
- RAMs return mmem word 0x7F80_0102_FEFF_0010 and vmem word 0x0102_0304_0506_0708 -> dot_vec0/dot_vec1 equal those words bit-exact, two cycles after issue.
- cfg_rows=0, C=4 -> done in cycle 1, ren never asserted, busy stays 0. Repeat with R=3, C=0 -> same response.
- R=1, C=4, start pulsed again in cycles 2 and 4 -> exactly 4 ivalids and a single done. Second start one cycle after done -> new job runs normally.
- R=2, C=2, rst asserted in cycle 3 -> all outputs 0 from the next cycle, no done, no further ren. Subsequent start (R=1, C=1) -> 1 chunk with first=last=1 and done.
- FEEDER_HOLD_EN, R=1, C=4, hold high in cycles 2-3 -> ren in cycles 1, 4, 5, 6; dot_ivalid in cycles 3, 6, 7, 8; addresses 0,1,2,3 with no skips or repeats; done in cycle 8.
